// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared ghost-mode constants, schedule defaults and encodings
package ghost_pkg;

  localparam int NUM_TIMED_PHASES = 7;
  // Arcade level-1 schedule in 60 Hz ticks; phase 7 is an endless chase.
  localparam int PHASE_TICKS [0:NUM_TIMED_PHASES-1] = '{420, 1200, 420, 1200, 300, 1200, 300};
  localparam int FRIGHT_TICKS_DEF = 360;
  localparam int FLASH_TICKS_DEF = 120;

  typedef enum logic [1:0] {
    MODE_SCATTER,
    MODE_CHASE,
    MODE_FRIGHT
  } ghostModeT;

  typedef enum logic {
    IDLE,
    RUN
  } schedStateT;

  typedef enum logic {
    FR_OFF,
    FR_ON
  } frightStateT;

endpackage

// File: rtl/ghost_fright_timer.sv
// rtl/ghost_fright_timer.sv - frightened-overlay down-counter with flash window
module ghost_fright_timer
  import ghost_pkg::*;
#(
  parameter int FW = 9,
  parameter int FRIGHT_TICKS = FRIGHT_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  input  logic clear,
  output logic active,
  output logic flash,
  output logic activeNext
);

  logic [FW-1:0] count;
  logic [FW-1:0] countNext;
  frightStateT   frState;
  frightStateT   frStateNext;
  logic          flashNext;

  always_comb begin
    countNext = count;
    if (clear) begin
      countNext = '0;
    end else if (load) begin
      countNext = FW'(FRIGHT_TICKS);
    end else if (tick && frState == FR_ON) begin
      countNext = count - FW'(1);
    end
  end

  // A zero-length fright load leaves the overlay off; the caller still reverses.
  always_comb begin
    frStateNext = (countNext != '0) ? FR_ON : FR_OFF;
    flashNext   = (frStateNext == FR_ON) && (countNext <= FW'(FLASH_TICKS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      frState <= FR_OFF;
      flash   <= 1'b0;
    end else begin
      count   <= countNext;
      frState <= frStateNext;
      flash   <= flashNext;
    end
  end

  assign active     = (frState == FR_ON);
  assign activeNext = (frStateNext == FR_ON);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - global scatter/chase/frightened sequencer for the ghost movers
module ghost_mode_scheduler
  import ghost_pkg::*;
#(
  parameter int T_S0 = PHASE_TICKS[0],
  parameter int T_C0 = PHASE_TICKS[1],
  parameter int T_S1 = PHASE_TICKS[2],
  parameter int T_C1 = PHASE_TICKS[3],
  parameter int T_S2 = PHASE_TICKS[4],
  parameter int T_C2 = PHASE_TICKS[5],
  parameter int T_S3 = PHASE_TICKS[6],
  parameter int FRIGHT_TICKS = FRIGHT_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int CW = 11,
  parameter int FW = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       level_start,
  input  logic       energizer,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       flash,
  output logic       reverse,
  output logic [2:0] phase
);

  localparam logic [2:0] LAST_PHASE = 3'd7;

  schedStateT    state;
  schedStateT    stateNext;
  logic [2:0]    phaseNext;
  logic [CW-1:0] timer;
  logic [CW-1:0] timerNext;
  logic [CW-1:0] phaseEnd;
  logic          reverseNext;
  logic          effTick;
  logic          frLoad;
  logic          frClear;
  logic          frTick;
  logic          frActiveNext;
  ghostModeT     modeNext;
  logic          scatterNext;
  logic          chaseNext;

  assign effTick = tick & ~pause;

  always_comb begin
    case (phase)
      3'd0:    phaseEnd = CW'(T_S0 - 1);
      3'd1:    phaseEnd = CW'(T_C0 - 1);
      3'd2:    phaseEnd = CW'(T_S1 - 1);
      3'd3:    phaseEnd = CW'(T_C1 - 1);
      3'd4:    phaseEnd = CW'(T_S2 - 1);
      3'd5:    phaseEnd = CW'(T_C2 - 1);
      3'd6:    phaseEnd = CW'(T_S3 - 1);
      default: phaseEnd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      timer     <= '0;
      reverse   <= 1'b0;
      isScatter <= 1'b0;
      isChase   <= 1'b0;
    end else begin
      state     <= stateNext;
      phase     <= phaseNext;
      timer     <= timerNext;
      reverse   <= reverseNext;
      isScatter <= scatterNext;
      isChase   <= chaseNext;
    end
  end

  // The schedule is frozen while frightened; an energizer consumes any coincident tick.
  always_comb begin
    stateNext   = state;
    phaseNext   = phase;
    timerNext   = timer;
    reverseNext = 1'b0;
    frLoad      = 1'b0;
    frClear     = 1'b0;
    frTick      = 1'b0;
    if (level_start) begin
      stateNext = RUN;
      phaseNext = '0;
      timerNext = '0;
      frClear   = 1'b1;
    end else if (state == RUN) begin
      if (energizer) begin
        frLoad      = 1'b1;
        reverseNext = 1'b1;
      end else if (effTick) begin
        if (isFrightened) begin
          frTick = 1'b1;
        end else if (phase != LAST_PHASE) begin
          if (timer == phaseEnd) begin
            phaseNext   = phase + 3'd1;
            timerNext   = '0;
            reverseNext = 1'b1;
          end else begin
            timerNext = timer + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    modeNext = phaseNext[0] ? MODE_CHASE : MODE_SCATTER;
    if (frActiveNext) begin
      modeNext = MODE_FRIGHT;
    end
    scatterNext = (stateNext == RUN) && (modeNext == MODE_SCATTER);
    chaseNext   = (stateNext == RUN) && (modeNext == MODE_CHASE);
  end

  ghost_fright_timer #(
    .FW(FW),
    .FRIGHT_TICKS(FRIGHT_TICKS),
    .FLASH_TICKS(FLASH_TICKS)
  ) frightTimer (
    .clk(clk),
    .reset(reset),
    .load(frLoad),
    .tick(frTick),
    .clear(frClear),
    .active(isFrightened),
    .flash(flash),
    .activeNext(frActiveNext)
  );

endmodule
